// File: rtl/pwm_fader.sv
// pwm_fader: duty-cycle ramp sequencer feeding a sync-latching PWM wrapper.
// It steps value_out from its present value toward a latched target.
// Each step lands only on a PWM period start, and every step is held for
// hold+1 periods.
//
// Ports:
//   clk       system clock, all state on posedge
//   rst       asynchronous active-low reset
//   start     ramp request, honoured only while busy=0
//   target    final duty value (clamped to MAXVAL when latched)
//   step      per-update increment/decrement (0 is treated as 1)
//   hold      extra periods per step
//   abort     stops a ramp in progress and freezes value_out
//   sync      period-start flag from the PWM core
//   value_out duty value to the wrapper's value_in
//   busy      ramp in progress
//   done      one-cycle pulse when value_out reaches the target
//
// state  | meaning
// IDLE   | waiting for start, busy=0
// RAMP   | counting sync rising edges and applying steps, busy=1
// FINISH | single cycle with done=1; start is accepted here too
module pwm_fader #(
  parameter int WIDTH  = 8,
  parameter int MAXVAL = 255,
  parameter int HOLDW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step,
  input  logic [HOLDW-1:0] hold,
  input  logic             abort,
  input  logic             sync,
  output logic [WIDTH-1:0] value_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAMP   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAXVAL);

  state_t           r_state;
  logic             r_sync_q;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_step;
  logic [HOLDW-1:0] r_hold;
  logic [HOLDW-1:0] r_cnt;

  logic             w_sync_evt;
  logic [WIDTH-1:0] w_tgt_clamp;
  logic [WIDTH-1:0] w_step_lat;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_next;

  assign w_sync_evt  = sync & ~r_sync_q;
  assign w_tgt_clamp = (target > MAX_V) ? MAX_V : target;
  assign w_step_lat  = (step == '0) ? WIDTH'(1) : step;

  // One extra bit catches overflow on the way up and borrow on the way down.
  assign w_sum  = {1'b0, value_out} + {1'b0, r_step};
  assign w_diff = {1'b0, value_out} - {1'b0, r_step};

  always_comb begin
    w_next = r_tgt;
    if (r_tgt > value_out) begin
      if (w_sum < {1'b0, r_tgt}) w_next = w_sum[WIDTH-1:0];
    end else begin
      if (!w_diff[WIDTH] && (w_diff[WIDTH-1:0] > r_tgt)) w_next = w_diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sync_q  <= 1'b0;
      r_tgt     <= '0;
      r_step    <= '0;
      r_hold    <= '0;
      r_cnt     <= '0;
      value_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // sync_q follows sync in every state.
      // A sync that is already high at start is therefore not an event.
      r_sync_q <= sync;
      done     <= 1'b0;
      case (r_state)
        S_IDLE, S_FINISH: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          if (start && !abort) begin
            r_tgt  <= w_tgt_clamp;
            r_step <= w_step_lat;
            r_hold <= hold;
            r_cnt  <= '0;
            if (w_tgt_clamp == value_out) begin
              r_state <= S_FINISH;
              done    <= 1'b1;
            end else begin
              r_state <= S_RAMP;
              busy    <= 1'b1;
            end
          end
        end
        S_RAMP: begin
          if (abort) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else if (w_sync_evt) begin
            if (r_cnt == r_hold) begin
              value_out <= w_next;
              r_cnt     <= '0;
              if (w_next == r_tgt) begin
                r_state <= S_FINISH;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + HOLDW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fader.sv
// Scoreboard bench for pwm_fader. Stimulus pushes the expected value_out
// changes and done pulses. Monitors pop and compare whenever a DUT shows
// either one. The second instance uses MAXVAL=100 to exercise target clamping.
module tb_pwm_fader;

  typedef struct {
    bit is_done;
    int val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] target;
  logic [7:0] step;
  logic [7:0] hold;
  logic       abort;
  logic       sync;
  logic [7:0] value_out;
  logic       busy;
  logic       done;

  logic       start2;
  logic [7:0] target2;
  logic [7:0] step2;
  logic [7:0] hold2;
  logic [7:0] value2;
  logic       busy2;
  logic       done2;

  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q2[$];

  pwm_fader #(.WIDTH(8), .MAXVAL(255), .HOLDW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .step(step),
    .hold(hold), .abort(abort), .sync(sync), .value_out(value_out),
    .busy(busy), .done(done)
  );

  pwm_fader #(.WIDTH(8), .MAXVAL(100), .HOLDW(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .target(target2), .step(step2),
    .hold(hold2), .abort(abort), .sync(sync), .value_out(value2),
    .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push1(input bit d, input int v);
    exp_t e;
    e.is_done = d;
    e.val = v;
    q1.push_back(e);
  endtask

  task automatic push2(input bit d, input int v);
    exp_t e;
    e.is_done = d;
    e.val = v;
    q2.push_back(e);
  endtask

  // Monitor for the main instance.
  initial begin
    logic [7:0] prev;
    exp_t e;
    prev = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = value_out;
      end else begin
        if (value_out !== prev) begin
          checks++;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL mon1_value: got unexpected value %0d, expected no change", value_out);
          end else begin
            e = q1.pop_front();
            if (e.is_done || e.val != int'(value_out)) begin
              errors++;
              $display("FAIL mon1_value: got value %0d, expected %s %0d",
                       value_out, e.is_done ? "done at" : "value", e.val);
            end
          end
          prev = value_out;
        end
        if (done === 1'b1) begin
          checks++;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL mon1_done: got unexpected done at value %0d, expected none", value_out);
          end else begin
            e = q1.pop_front();
            if (!e.is_done || e.val != int'(value_out) || busy !== 1'b0) begin
              errors++;
              $display("FAIL mon1_done: got done at value %0d busy %0d, expected %s %0d busy 0",
                       value_out, busy, e.is_done ? "done at" : "value", e.val);
            end
          end
        end
      end
    end
  end

  // Monitor for the clamping instance.
  initial begin
    logic [7:0] prev;
    exp_t e;
    prev = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = value2;
      end else begin
        if (value2 !== prev) begin
          checks++;
          if (q2.size() == 0) begin
            errors++;
            $display("FAIL mon2_value: got unexpected value %0d, expected no change", value2);
          end else begin
            e = q2.pop_front();
            if (e.is_done || e.val != int'(value2)) begin
              errors++;
              $display("FAIL mon2_value: got value %0d, expected %s %0d",
                       value2, e.is_done ? "done at" : "value", e.val);
            end
          end
          prev = value2;
        end
        if (done2 === 1'b1) begin
          checks++;
          if (q2.size() == 0) begin
            errors++;
            $display("FAIL mon2_done: got unexpected done at value %0d, expected none", value2);
          end else begin
            e = q2.pop_front();
            if (!e.is_done || e.val != int'(value2)) begin
              errors++;
              $display("FAIL mon2_done: got done at value %0d, expected %s %0d",
                       value2, e.is_done ? "done at" : "value", e.val);
            end
          end
        end
      end
    end
  end

  task automatic sync_pulse(input int hi);
    @(negedge clk);
    sync = 1'b1;
    repeat (hi) @(negedge clk);
    sync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_start(input int t, input int s, input int h);
    @(negedge clk);
    target = 8'(t);
    step   = 8'(s);
    hold   = 8'(h);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d/%0d expectations still pending, expected 0",
               name, q1.size(), q2.size());
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; target = '0; step = '0; hold = '0;
    abort = 1'b0; sync = 1'b0;
    start2 = 1'b0; target2 = '0; step2 = '0; hold2 = '0;

    repeat (3) @(negedge clk);
    chk("reset_value", int'(value_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp up 0 -> 200, step 64, hold 0.
    push1(0, 64); push1(0, 128); push1(0, 192); push1(0, 200); push1(1, 200);
    do_start(200, 64, 0);
    chk("up_busy", int'(busy), 1);
    repeat (4) sync_pulse(1);
    drain("up_drain", 20);

    // Ramp down 200 -> 10, step 100, hold 2: one update per 3 sync edges.
    push1(0, 100); push1(0, 10); push1(1, 10);
    do_start(10, 100, 2);
    repeat (2) sync_pulse(1);
    chk("down_hold_value", int'(value_out), 200);
    sync_pulse(1);
    chk("down_first_step", int'(value_out), 100);
    repeat (3) sync_pulse(1);
    drain("down_drain", 20);

    // Step larger than value: would underflow, clamps to target 0.
    push1(0, 0); push1(1, 0);
    do_start(0, 255, 0);
    sync_pulse(1);
    drain("underflow_drain", 20);

    // Step 0 is treated as 1: 0 -> 3 in three updates.
    push1(0, 1); push1(0, 2); push1(0, 3); push1(1, 3);
    do_start(3, 0, 0);
    repeat (3) sync_pulse(1);
    drain("step0_drain", 20);

    // Target equals value: done the next cycle with no sync.
    // During that FINISH cycle a new start (-> 0, step 2) must be accepted.
    push1(1, 3);
    @(negedge clk);
    target = 8'd3; step = 8'd1; hold = 8'd0; start = 1'b1;
    @(negedge clk);
    chk("direct_done", int'(done), 1);
    target = 8'd0; step = 8'd2; hold = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("finish_start_busy", int'(busy), 1);
    // A sync held high for 5 cycles gives one update.
    push1(0, 1);
    sync_pulse(5);
    chk("long_sync_value", int'(value_out), 1);
    push1(0, 0); push1(1, 0);
    sync_pulse(1);
    drain("b2b_drain", 20);

    // Abort after the second update, with an ignored start while busy.
    push1(0, 64);
    do_start(200, 64, 0);
    sync_pulse(1);
    @(negedge clk);
    target = 8'd5; step = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push1(0, 128);
    sync_pulse(1);
    drain("abort_pre_drain", 20);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_value", int'(value_out), 128);
    sync_pulse(1);
    chk("abort_frozen", int'(value_out), 128);

    // Abort and start together in IDLE: nothing starts.
    @(negedge clk);
    target = 8'd50; step = 8'd10; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", int'(busy), 0);
    sync_pulse(1);
    chk("abort_start_value", int'(value_out), 128);

    // Reset in the middle of a ramp.
    push1(0, 138);
    do_start(255, 10, 0);
    sync_pulse(1);
    drain("prereset_drain", 20);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_value", int'(value_out), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) sync_pulse(1);
    chk("postreset_value", int'(value_out), 0);
    chk("postreset_busy", int'(busy), 0);

    // Clamp: MAXVAL=100 instance, target 250 -> 100, step 60.
    push2(0, 60); push2(0, 100); push2(1, 100);
    @(negedge clk);
    target2 = 8'd250; step2 = 8'd60; hold2 = 8'd0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("clamp_busy", int'(busy2), 1);
    repeat (2) sync_pulse(1);
    drain("clamp_drain", 20);
    chk("clamp_final", int'(value2), 100);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
